// File: rtl/mem32_to_16_splitter_pkg.sv
// Shared types and constants for the 32-to-16 bit memory access splitter.
package mem32_to_16_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic       HALF_LO       = 1'b0;
    localparam logic       HALF_HI       = 1'b1;
    localparam logic [1:0] DN_WSTRB_READ = 2'b00;

endpackage

// File: rtl/mem32_to_16_splitter_if.sv
// picorv32-style native memory bus; wstrb of zero marks a read.
interface mem32_to_16_splitter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic              valid;
    logic              ready;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic [DW-1:0]     rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem32_to_16_splitter.sv
// Splits each 32-bit CPU access into one or two 16-bit downstream accesses,
// low half first; empty write halves are skipped when SKIP_EMPTY is set.
module mem32_to_16_splitter
    import mem32_to_16_splitter_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic                   clk,
    input  logic                   nrst,
    mem32_to_16_splitter_if.slave  up,
    mem32_to_16_splitter_if.master dn
);

    state_t            state_q, state_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [15:0]       rdata_lo_q;
    logic              up_ready_q;
    logic [31:0]       up_rdata_q;
    logic              dn_valid_q, dn_valid_d;
    logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
    logic [15:0]       dn_wdata_q, dn_wdata_d;
    logic [1:0]        dn_wstrb_q, dn_wstrb_d;
    logic              is_read, skip_lo, skip_hi, half_d;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{up.addr[31:ADDR_W+1], up.addr[1:0]};

    assign is_read = (wstrb_q == 4'b0000);
    assign skip_lo = SKIP_EMPTY && (up.wstrb != 4'b0000) && (up.wstrb[1:0] == 2'b00);
    assign skip_hi = SKIP_EMPTY && !is_read && (wstrb_q[3:2] == 2'b00);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: if (up.valid && !up_ready_q) begin
                addr_d  = up.addr[ADDR_W:2];
                wdata_d = up.wdata;
                wstrb_d = up.wstrb;
                state_d = skip_lo ? HI : LO;
            end
            LO:      if (dn.ready) state_d = skip_hi ? DONE : HI;
            HI:      if (dn.ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Downstream outputs are registered from the next state so that
        // LO->HI keeps dn_valid high and only address/data/strobes change.
        dn_valid_d = (state_d == LO) || (state_d == HI);
        half_d     = (state_d == HI) ? HALF_HI : HALF_LO;
        dn_addr_d  = '0;
        dn_wdata_d = '0;
        dn_wstrb_d = DN_WSTRB_READ;
        if (dn_valid_d) begin
            dn_addr_d  = {addr_d, half_d};
            dn_wdata_d = half_d ? wdata_d[31:16] : wdata_d[15:0];
            dn_wstrb_d = half_d ? wstrb_d[3:2]   : wstrb_d[1:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_lo_q <= '0;
            up_ready_q <= 1'b0;
            up_rdata_q <= '0;
            dn_valid_q <= 1'b0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            dn_wstrb_q <= DN_WSTRB_READ;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            up_ready_q <= (state_d == DONE);
            dn_valid_q <= dn_valid_d;
            dn_addr_q  <= dn_addr_d;
            dn_wdata_q <= dn_wdata_d;
            dn_wstrb_q <= dn_wstrb_d;
            if (state_q == LO && dn.ready && is_read)
                rdata_lo_q <= dn.rdata;
            // Reads always finish in HI, so the full word is loaded at once.
            if (state_q == HI && dn.ready && is_read)
                up_rdata_q <= {dn.rdata, rdata_lo_q};
        end
    end

    assign up.ready = up_ready_q;
    assign up.rdata = up_rdata_q;
    assign dn.valid = dn_valid_q;
    assign dn.addr  = dn_addr_q;
    assign dn.wdata = dn_wdata_q;
    assign dn.wstrb = dn_wstrb_q;

endmodule
